// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM,
// and queues {pc, instr} pairs in a small FIFO that decode drains via valid/ready.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1
);

    localparam int               PTR_W     = (DEPTH > 2) ? 2 : 1;
    localparam int               CNT_W     = 3;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [15:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      buf_pc_q    [DEPTH];
    logic [15:0]      buf_instr_q [DEPTH];
    logic             pop_s;
    logic             push_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_s  = (count_q != {CNT_W{1'b0}}) & id_ready;
    assign push_s = ~redirect_valid & ((count_q < DEPTH_CNT) | pop_s);

    // Next-state for PC, pointers and occupancy; redirect overrides any push.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = tail_q;
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_d   = pc_q + 16'h0001;
                tail_d = ptr_inc(tail_q);
            end else begin
                pc_d   = pc_q;
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Fetch buffer storage, written at the tail on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]    <= 16'h0000;
                buf_instr_q[i] <= 16'h0000;
            end
        end else if (push_s) begin
            buf_pc_q[tail_q]    <= pc_q;
            buf_instr_q[tail_q] <= rom_data;
        end
    end

    // Head outputs come straight from registers and read zero when empty.
    assign rom_addr    = pc_q;
    assign if_valid    = (count_q != {CNT_W{1'b0}});
    assign if_instr    = if_valid ? buf_instr_q[head_q] : 16'h0000;
    assign if_pc       = if_valid ? buf_pc_q[head_q] : 16'h0000;
    assign if_pc_plus1 = if_valid ? (buf_pc_q[head_q] + 16'h0001) : 16'h0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based fetch model checked every cycle,
// plus literal expectations for each scenario.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        id_ready = 1'b1;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;

    int errors = 0;
    int checks = 0;
    int n40    = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    ent_t        hd;
    logic [15:0] m_pc;
    bit          m_pop;
    bit          m_push;

    always #5 clk = ~clk;

    // ROM contents: word at address a is a + 0x1001, so ROM[0..3] = 1001..1004.
    assign rom_data = rom_addr + 16'h1001;

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus1(if_pc_plus1)
    );

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Behavioural model: a FIFO of fetched {pc, instr} pairs and a PC.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc = 16'h0000;
        end else begin
            m_pop  = (mq.size() != 0) && id_ready;
            m_push = !redirect_valid && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc;
            end else if (m_push) begin
                mq.push_back({m_pc, m_pc + 16'h1001});
                m_pc = m_pc + 16'h0001;
            end
        end
    end

    // Count DUT handshakes delivering pc 0x0040.
    always @(posedge clk) begin
        if (!rst && if_valid && id_ready && if_pc == 16'h0040) n40++;
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        hd = (mq.size() != 0) ? mq[0] : '0;
        chk1 ("cyc_valid", if_valid, mq.size() != 0);
        chk16("cyc_instr", if_instr, hd.instr);
        chk16("cyc_pc", if_pc, hd.pc);
        chk16("cyc_pc_plus1", if_pc_plus1, (mq.size() != 0) ? hd.pc + 16'h0001 : 16'h0000);
        chk16("cyc_rom_addr", rom_addr, m_pc);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset / stream
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk1 ("t1_reset_valid", if_valid, 1'b0);
        chk16("t1_reset_rom_addr", rom_addr, 16'h0000);
        chk16("t1_reset_pc", if_pc, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk1 ("t1_valid", if_valid, 1'b1);
            chk16("t1_instr", if_instr, 16'h1001 + 16'(i));
            chk16("t1_pc", if_pc, 16'(i));
            chk16("t1_pc_plus1", if_pc_plus1, 16'(i + 1));
        end

        // Backpressure / full
        rst = 1'b1;
        id_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        cyc();
        chk16("t2_full_rom_addr", rom_addr, 16'h0002);
        chk16("t2_full_instr", if_instr, 16'h1001);
        cyc();
        chk16("t2_hold_rom_addr", rom_addr, 16'h0002);
        chk16("t2_hold_instr", if_instr, 16'h1001);
        id_ready = 1'b1;
        cyc();
        chk16("t2_resume_1002", if_instr, 16'h1002);
        cyc();
        chk16("t2_resume_1003", if_instr, 16'h1003);

        // Redirect with buffer full
        rst = 1'b1;
        id_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk16("t3_head_pc", if_pc, 16'h0000);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        cyc();
        redirect_valid = 1'b0;
        chk1 ("t3_flushed_valid", if_valid, 1'b0);
        chk16("t3_rom_addr", rom_addr, 16'h0040);
        cyc();
        chk1 ("t3_valid", if_valid, 1'b1);
        chk16("t3_pc", if_pc, 16'h0040);
        chk16("t3_instr", if_instr, 16'h1041);

        // Redirect coincident with pop
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        cyc();
        redirect_valid = 1'b0;
        chk16("t4_pop_once", 16'(n40), 16'h0001);
        chk1 ("t4_flushed_valid", if_valid, 1'b0);
        chk16("t4_rom_addr", rom_addr, 16'h0010);
        cyc();
        chk16("t4_target_pc", if_pc, 16'h0010);
        cyc();
        chk16("t4_next_pc", if_pc, 16'h0011);
        chk16("t4_still_once", 16'(n40), 16'h0001);

        // Wrap-around
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk16("t5_pc", if_pc, 16'hFFFF);
        chk16("t5_pc_plus1", if_pc_plus1, 16'h0000);
        chk16("t5_instr", if_instr, 16'h1000);
        cyc();
        chk16("t5_wrap_pc", if_pc, 16'h0000);
        chk16("t5_wrap_pc_plus1", if_pc_plus1, 16'h0001);

        // Async reset mid-stream with a full buffer
        id_ready = 1'b0;
        cyc();
        cyc();
        cyc();
        chk1("t6_valid_before", if_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("t6_async_valid", if_valid, 1'b0);
        chk16("t6_async_rom_addr", rom_addr, 16'h0000);
        chk16("t6_async_pc", if_pc, 16'h0000);
        cyc();
        rst = 1'b0;
        id_ready = 1'b1;
        cyc();
        chk16("t6_restart_pc", if_pc, 16'h0000);
        chk16("t6_restart_instr", if_instr, 16'h1001);
        cyc();
        chk16("t6_restart_next", if_pc, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Holds the program counter and drives the instruction ROM address.
- The ROM read is combinational. The returned word is captured together with its PC into a small FIFO buffer.
- Buffered instructions are presented to decode through a valid/ready handshake.
- Branch and jump redirects from later stages flush the buffer and reload the PC.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DEPTH, 2, fetch buffer entries; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rom_addr  output  16  ROM address; equals the PC register.
- rom_data  input  16  ROM read data for rom_addr; valid in the same cycle.
- redirect_valid  input  1  redirect request from execute/writeback.
- redirect_pc  input  16  redirect target address.
- id_ready  input  1  decode can accept an instruction this cycle.
- if_valid  output  1  buffer head is valid.
- if_instr  output  16  instruction at buffer head.
- if_pc  output  16  address of if_instr.
- if_pc_plus1  output  16  if_pc + 1, modulo 2^16.

Behaviour:
- Reset (async, while rst=1):
  - pc = RESET_PC.
  - count = 0, head/tail pointers = 0.
  - if_valid = 0; if_instr, if_pc, if_pc_plus1 = 0.
  - rom_addr = RESET_PC.
- Defined signals:
  - pop = if_valid & id_ready.
  - push = !redirect_valid & (count < DEPTH | pop).
- if_valid = (count != 0). It depends only on registered state; there is no combinational path from id_ready or redirect to if_valid.
- When count == 0, if_instr, if_pc and if_pc_plus1 read 0.
- Push (rising edge):
  - Write {pc, rom_data} at tail.
  - tail advances mod DEPTH.
  - pc <= pc + 1; 16'hFFFF wraps to 16'h0000.
- Pop (rising edge): head advances mod DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when push and pop occur together.
- Full buffer (count == DEPTH):
  - Fetch continues only if a pop occurs in the same cycle.
  - Otherwise pc holds and rom_addr stays stable.
- Redirect (redirect_valid=1 at an edge), highest priority:
  - pc <= redirect_pc.
  - count <= 0, head <= tail.
  - No push that cycle.
  - A pop in the same cycle counts as a completed transfer (decode owns it); all other entries are discarded.
- Redirect latency:
  - Redirect at edge N: rom_addr = target during cycle N+1.
  - Target instruction is pushed at edge N+1.
  - if_valid = 1 with if_pc = target in cycle N+2.
- Startup latency: first edge after rst deasserts pushes mem[RESET_PC]; if_valid rises one cycle later.
- Back-to-back redirects: the last one wins; each flushes again.
- Redirect to the current pc value is legal and behaves identically to any other redirect (flush plus refetch).
- Reset asserted mid-operation: all state is immediately forced to reset values, regardless of the clock.
- Throughput: one instruction per cycle sustained while id_ready=1 and no redirect.
- Ordering: instructions leave in strict PC order between redirects.
- Arithmetic is 16-bit unsigned throughout; no overflow flag.

Test Plan:
- Reset/stream:
  - Stimulus: ROM[0..3] = 16'h1001, 16'h1002, 16'h1003, 16'h1004; RESET_PC=0; id_ready=1 constantly.
  - Required response: if_valid rises in the 2nd cycle after reset release.
  - if_instr sequence 1001, 1002, 1003, 1004 on consecutive cycles, with if_pc 0..3 and if_pc_plus1 1..4.
- Backpressure/full:
  - Stimulus: id_ready=0 from reset.
  - Required response: count saturates at 2 and pc holds at 2 with rom_addr=2.
  - if_instr holds 1001.
  - Raising id_ready resumes the stream 1001, 1002, 1003 without loss or duplication.
- Redirect with buffer full:
  - Stimulus: buffer holds pc 0,1; pulse redirect_valid with redirect_pc=16'h0040 while id_ready=0.
  - Required response: next cycle if_valid=0 and rom_addr=0x0040; following cycle if_pc=0x0040 with instr=ROM[0x40].
- Redirect coincident with pop:
  - Stimulus: id_ready=1 and redirect to 0x0010 on the same edge.
  - Required response: the head entry counts as transferred exactly once; no stale entry appears afterwards; the next valid if_pc is 0x0010.
- Wrap-around:
  - Stimulus: redirect to 16'hFFFF.
  - Required response: if_pc 0xFFFF with if_pc_plus1 0x0000, followed by if_pc 0x0000.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while count=2.
  - Required response: if_valid=0 and rom_addr=RESET_PC before the next edge; fetch restarts from RESET_PC after release.
